// File: rtl/led_pattern_engine.sv
// led_pattern_engine: steps an LED pattern once per prescaler period.
//
// Optional feature: define LED_PWM_EN to add a 4-bit global brightness
// input. A free-running 16-step PWM counter then gates the lit LEDs.
//
// Parameters
//   N_LED   : number of LED outputs (2..32)
//   CLK_HZ  : sys_clk frequency in Hz
//   STEP_MS : pattern step period in ms (TICK_CYC = CLK_HZ/1000*STEP_MS)
//
// Ports
//   sys_clk    in   sole clock, rising edge
//   sys_rst_n  in   asynchronous active-low reset
//   mode[1:0]  in   00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count
//   pause      in   high freezes the prescaler and the pattern
//   brightness in   [3:0] duty select (LED_PWM_EN only)
//   led        out  [N_LED-1:0] active-low LED drive, registered
module led_pattern_engine #(
    parameter int unsigned N_LED   = 6,
    parameter int unsigned CLK_HZ  = 27000000,
    parameter int unsigned STEP_MS = 500
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [1:0]       mode,
    input  logic             pause,
`ifdef LED_PWM_EN
    input  logic [3:0]       brightness,
`endif
    output logic [N_LED-1:0] led
);

    localparam int unsigned TICK_CYC = CLK_HZ / 1000 * STEP_MS;
    localparam int unsigned CNT_W    = $clog2(TICK_CYC);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_CYC - 1);

    typedef enum logic [1:0] {
        MODE_ROL    = 2'b00,
        MODE_ROR    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_COUNT  = 2'b11
    } mode_e;

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [N_LED-1:0] pat_q,   pat_d;
    logic             dir_q,   dir_d;
    mode_e            mode_q,  mode_d;
    logic [N_LED-1:0] led_q,   led_d;
    logic             tick_c;
    mode_e            mode_in_c;

`ifdef LED_PWM_EN
    logic [3:0]       pwm_cnt_q, pwm_cnt_d;
    logic             pwm_on_c;
`endif

    // State registers
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            presc_q <= '0;
            pat_q   <= N_LED'(1);
            dir_q   <= 1'b0;
            mode_q  <= MODE_ROL;
            led_q   <= ~N_LED'(1);
`ifdef LED_PWM_EN
            pwm_cnt_q <= 4'd0;
`endif
        end else begin
            presc_q <= presc_d;
            pat_q   <= pat_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            led_q   <= led_d;
`ifdef LED_PWM_EN
            pwm_cnt_q <= pwm_cnt_d;
`endif
        end
    end

    // Prescaler, mode latch and pattern step
    always_comb begin
        presc_d   = presc_q;
        pat_d     = pat_q;
        dir_d     = dir_q;
        mode_d    = mode_q;
        mode_in_c = mode_e'(mode);
        tick_c    = (presc_q == TICK_LAST) && !pause;

        if (!pause) begin
            presc_d = (presc_q == TICK_LAST) ? '0 : presc_q + CNT_W'(1);
        end

        if (tick_c) begin
            if (mode_in_c != mode_q) begin
                // Mode switch restarts from bit 0; no step this tick
                mode_d = mode_in_c;
                pat_d  = N_LED'(1);
                dir_d  = 1'b0;
            end else begin
                case (mode_q)
                    MODE_ROL: pat_d = {pat_q[N_LED-2:0], pat_q[N_LED-1]};
                    MODE_ROR: pat_d = {pat_q[0], pat_q[N_LED-1:1]};
                    MODE_BOUNCE: begin
                        // End positions reverse immediately, so each end is lit once
                        if (!dir_q) begin
                            if (pat_q[N_LED-1]) begin
                                pat_d = pat_q >> 1;
                                dir_d = 1'b1;
                            end else begin
                                pat_d = pat_q << 1;
                            end
                        end else begin
                            if (pat_q[0]) begin
                                pat_d = pat_q << 1;
                                dir_d = 1'b0;
                            end else begin
                                pat_d = pat_q >> 1;
                            end
                        end
                    end
                    MODE_COUNT: pat_d = pat_q + N_LED'(1);
                    default:    pat_d = pat_q;
                endcase
            end
        end
    end

    // Output drive: led registered from next pattern so it moves with the wrap
`ifdef LED_PWM_EN
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        pwm_on_c  = (pwm_cnt_d < brightness);
        led_d     = ~(pat_d & {N_LED{pwm_on_c}});
    end
`else
    always_comb begin
        led_d = ~pat_d;
    end
`endif

    assign led = led_q;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine (N_LED=6, TICK_CYC=4).
// Stimulus pushes {cycle, expected} entries; the monitor checks led at the
// falling edge of the matching cycle.
module tb_led_pattern_engine;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode  = 2'b00;
    logic       pause = 1'b0;
    logic [5:0] led;
`ifdef LED_PWM_EN
    logic [3:0] brightness = 4'd0;
`endif

    led_pattern_engine #(
        .N_LED  (6),
        .CLK_HZ (1000),
        .STEP_MS(4)
    ) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .mode      (mode),
        .pause     (pause),
`ifdef LED_PWM_EN
        .brightness(brightness),
`endif
        .led       (led)
    );

    always #5 clk = ~clk;

    // Edges seen so far
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [5:0]  exp;
        int          kind;   // 0: compare led, 1: compare act
        logic [5:0]  act;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic push(input int unsigned c, input logic [5:0] v, input string nm);
        sb.push_back('{c, v, 0, 6'd0, nm});
    endtask

    task automatic push_val(input logic [5:0] v, input logic [5:0] a, input string nm);
        sb.push_back('{cyc, v, 1, a, nm});
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [5:0] a;
            e = sb.pop_front();
            tests++;
            a = (e.kind == 0) ? led : e.act;
            if (e.cyc < cyc) begin
                fails++;
                $display("FAIL %s: check missed, due cycle %0d now %0d", e.name, e.cyc, cyc);
            end else if (a !== e.exp) begin
                fails++;
                $display("FAIL %s: cycle %0d got %b expected %b", e.name, cyc, a, e.exp);
            end
        end
    end

    initial begin
        int unsigned r, t0, p, q, b;
        int bnc[12];
        logic [5:0] one;
        one = 6'd1;
        bnc = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1, 2};

`ifdef LED_PWM_EN
        begin
            int lows, others;
            brightness = 4'd4;
            pause = 1'b1;
            wait_cyc(3);
            push(cyc, 6'b111110, "pwm_reset");
            rst_n = 1'b1;
            lows = 0;
            others = 0;
            for (int i = 0; i < 32; i++) begin
                wait_cyc(1);
                if (led[0] == 1'b0) lows++;
                if (led[5:1] !== 5'b11111) others++;
            end
            push_val(6'd8, 6'(lows), "pwm_b4_low_count");
            push_val(6'd0, 6'(others), "pwm_unlit_dark");
            brightness = 4'd0;
            wait_cyc(1);
            lows = 0;
            for (int i = 0; i < 16; i++) begin
                wait_cyc(1);
                if (led[0] == 1'b0) lows++;
            end
            push_val(6'd0, 6'(lows), "pwm_b0_low_count");
            push(cyc + 1, 6'b111111, "pwm_b0_all_dark");
        end
`else
        // Reset and rotate-left
        wait_cyc(3);
        push(cyc, 6'b111110, "reset_hold");
        rst_n = 1'b1;
        r = cyc;
        push(r + 3,  6'b111110, "pre_first_tick");
        push(r + 4,  6'b111101, "rol_t1");
        push(r + 8,  6'b111011, "rol_t2");
        push(r + 24, 6'b111110, "rol_wrap");
        wait_cyc(24);
        t0 = cyc;

        // Mode change between ticks takes effect on next tick
        push(t0 + 8, 6'b111011, "rol_t8");
        wait_cyc(9);
        mode = 2'b01;
        push(t0 + 11, 6'b111011, "mode_hold_between");
        push(t0 + 12, 6'b111110, "mode_change_reload");
        push(t0 + 16, 6'b011111, "ror_first");
        wait_cyc(7);
        p = cyc;

        // Pause across a tick point with prescaler at 3
        wait_cyc(3);
        pause = 1'b1;
        push(p + 4,  6'b011111, "pause_tick_blocked");
        push(p + 13, 6'b011111, "pause_frozen");
        wait_cyc(10);
        pause = 1'b0;
        push(p + 14, 6'b101111, "resume_step");
        push(p + 18, 6'b110111, "ror_after_resume");
        wait_cyc(6);

        // Asynchronous reset mid-step
        rst_n = 1'b0;
        push(cyc, 6'b111110, "async_reset");
        wait_cyc(2);
        mode = 2'b00;
        rst_n = 1'b1;
        q = cyc;
        push(q + 3, 6'b111110, "reset_discard_partial");
        push(q + 4, 6'b111101, "first_tick_after_reset");
        wait_cyc(4);

        // Bounce
        mode = 2'b10;
        push(q + 8, 6'b111110, "bounce_enter");
        for (int k = 0; k < 12; k++)
            push(q + 12 + 4 * k, ~(one << bnc[k]), $sformatf("bounce_%0d", k + 1));
        wait_cyc(52);
        b = cyc;

        // Binary count
        mode = 2'b11;
        for (int k = 1; k <= 64; k++)
            push(b + 4 * k, ~6'(k), $sformatf("count_%0d", k));
`endif

        for (int i = 0; i < 400 && sb.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            $display("FAIL timeout: %0d checks pending, expected 0", sb.size());
            tests += sb.size();
            fails += sb.size();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
